// File: rtl/adc_scan_pkg.sv
// Shared encodings and data_out word layout for the ADC scan sequencer.
// Imported by adc_scan_sequencer and adc_scan_prio_enc.
package adc_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_EMIT  = ST_EMIT
  } state_t;

  localparam int CH_LSB  = 28;
  localparam int CH_W    = 4;
  localparam int CNT_LSB = 16;
  localparam int CNT_W   = 12;
  localparam int SMP_LSB = 0;
  localparam int SMP_W   = 16;

  localparam int AVG_N  = 4;
  localparam int AVG_SH = $clog2(AVG_N);
  localparam int ACC_W  = SMP_W + AVG_SH;

endpackage

// File: rtl/adc_scan_prio_enc.sv
// Lowest-set-bit priority encoder for the channel mask.
// Returns the bit index and whether any bit is set.
module adc_scan_prio_enc
  import adc_scan_pkg::*;
#(
  parameter int N = 8,
  parameter int W = CH_W
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans masked ADC channels in ascending order on each trigger.
// Define ADC_SCAN_AVG_EN to average 4 conversions per channel.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            trigger,
  output logic            measure_start,
  output logic [3:0]      measure_ch,
  input  logic            measure_done,
  input  logic [15:0]     measure_data,
  output logic [31:0]     data_out,
  output logic            data_out_valid,
  output logic            busy,
  output logic            overrun,
  output logic            timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t state, state_nx;

  logic [N_CH-1:0]  mask_q;
  logic [N_CH-1:0]  rem_mask;
  logic [N_CH-1:0]  ch_bit;
  logic [N_CH-1:0]  enc_in;
  logic [CH_W-1:0]  ch;
  logic [CH_W-1:0]  enc_idx;
  logic             enc_any;
  logic [CNT_W-1:0] scan_cnt;
  logic [SMP_W-1:0] sample_q;
  logic [SMP_W-1:0] sample_nx;
  logic [TW-1:0]    tmr;
  logic             done_q;
  logic             done_rise;
  logic             tmr_end;
  logic             cnv_last;
  logic             scan_go;

  assign done_rise = measure_done & ~done_q;
  assign tmr_end   = (tmr == TW'(TIMEOUT_CYC - 1));
  assign ch_bit    = N_CH'(1) << ch;
  assign rem_mask  = mask_q & ~ch_bit;

  // One encoder: live mask at scan start, remaining mask in EMIT
  assign enc_in  = (state == S_EMIT) ? rem_mask : ch_mask;
  assign scan_go = trigger & enable & enc_any;

  adc_scan_prio_enc #(
    .N (N_CH),
    .W (CH_W)
  ) u_enc (
    .mask (enc_in),
    .idx  (enc_idx),
    .any  (enc_any)
  );

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]       cnv;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum   = acc + ACC_W'(measure_data);
  assign cnv_last  = (cnv == 2'(AVG_N - 1));
  assign sample_nx = SMP_W'(acc_sum >> AVG_SH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnv <= '0;
      acc <= '0;
    end else if (state == S_IDLE || state == S_EMIT) begin
      cnv <= '0;
      acc <= '0;
    end else if (state == S_WAIT && done_rise) begin
      cnv <= cnv + 2'd1;
      acc <= acc_sum;
    end
  end
`else
  assign cnv_last  = 1'b1;
  assign sample_nx = measure_data;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    measure_start  = 1'b0;
    data_out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (scan_go) state_nx = S_START;
      end
      S_START: begin
        measure_start = 1'b1;
        state_nx      = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise)
          state_nx = cnv_last ? S_EMIT : S_START;
        else if (tmr_end)
          state_nx = S_IDLE;
      end
      S_EMIT: begin
        data_out_valid = 1'b1;
        if (enable && enc_any) state_nx = S_START;
        else                   state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_q   <= 1'b0;
      mask_q   <= '0;
      ch       <= '0;
      scan_cnt <= '0;
      sample_q <= '0;
      tmr      <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done_q <= measure_done;
      if (trigger && busy) overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (scan_go) begin
            mask_q <= ch_mask;
            ch     <= enc_idx;
          end
        end
        S_START: tmr <= '0;
        S_WAIT: begin
          if (done_rise) begin
            if (cnv_last) sample_q <= sample_nx;
          end else if (tmr_end) begin
            timeout <= 1'b1;
            mask_q  <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_EMIT: begin
          mask_q <= rem_mask;
          if (state_nx == S_START) ch <= enc_idx;
          else scan_cnt <= scan_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign measure_ch = ch;

  always_comb begin
    data_out = '0;
    data_out[CH_LSB  +: CH_W]  = ch;
    data_out[CNT_LSB +: CNT_W] = scan_cnt;
    data_out[SMP_LSB +: SMP_W] = sample_q;
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: ADC responder model plus word scoreboard.
// Scan table loop followed by hand-written multi-cycle corner cases.
module tb_adc_scan_sequencer;

  localparam int N_CH = 8;
  localparam int TO   = 64;
  localparam int LAT  = 20;
`ifdef ADC_SCAN_AVG_EN
  localparam int REP = 4;
`else
  localparam int REP = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [N_CH-1:0] ch_mask;
  logic            trigger;
  logic            measure_start;
  logic [3:0]      measure_ch;
  logic            measure_done;
  logic [15:0]     measure_data;
  logic [31:0]     data_out;
  logic            data_out_valid;
  logic            busy;
  logic            overrun;
  logic            timeout;

  int n_vec   = 0;
  int n_err   = 0;
  int n_start = 0;
  int n_valid = 0;
  int adc_cnt = 0;
  bit adc_en  = 1'b1;

  logic [31:0] sb[$];
  logic [15:0] adc_q[$];
  logic [11:0] exp_cnt = '0;
  logic [31:0] exp_w;

  typedef struct {
    logic [7:0]  mask;
    logic [15:0] base;
    int          words;
    logic [3:0]  first_ch;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .N_CH        (N_CH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .ch_mask        (ch_mask),
    .trigger        (trigger),
    .measure_start  (measure_start),
    .measure_ch     (measure_ch),
    .measure_done   (measure_done),
    .measure_data   (measure_data),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ADC controller model: done level rises LAT cycles after a start
  always @(negedge clk) begin
    if (measure_start) begin
      measure_done = 1'b0;
      adc_cnt = LAT;
    end else if (adc_cnt > 0) begin
      adc_cnt--;
      if (adc_cnt == 0 && adc_en) begin
        if (adc_q.size() != 0) measure_data = adc_q.pop_front();
        else measure_data = 16'h0;
        measure_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (measure_start) n_start++;
    if (data_out_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %08h required none", data_out);
      end else begin
        exp_w = sb.pop_front();
        check("word", 64'(data_out), 64'(exp_w));
      end
    end
  end

  task automatic pulse_trigger;
    @(posedge clk);
    #1 trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic queue_scan(input logic [7:0] m, input logic [15:0] base);
    for (int c = 0; c < N_CH; c++) begin
      if (m[c]) begin
        sb.push_back({4'(c), exp_cnt, 16'(base + 16'(c))});
        repeat (REP) adc_q.push_back(16'(base + 16'(c)));
      end
    end
  endtask

  task automatic wait_idle(input int bound, output int cyc, output logic pv);
    cyc = 0;
    pv  = 1'b0;
    while (busy && cyc < bound) begin
      pv = data_out_valid;
      @(negedge clk);
      cyc++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: busy=1 after %0d cycles, required 0", cyc);
    end
  endtask

  initial begin
    int   cyc;
    int   v0;
    int   s0;
    logic pv;

    tbl[0] = '{8'h80, 16'h0700, 1, 4'd7};
    tbl[1] = '{8'h18, 16'h0310, 2, 4'd3};
    tbl[2] = '{8'h00, 16'h0000, 0, 4'd0};
    tbl[3] = '{8'hFF, 16'h0F00, 8, 4'd0};
    tbl[4] = '{8'h42, 16'h0055, 2, 4'd1};

    reset_n      = 1'b0;
    enable       = 1'b1;
    trigger      = 1'b0;
    ch_mask      = '0;
    measure_done = 1'b0;
    measure_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, overrun, timeout, measure_start,
          data_out_valid, measure_ch, data_out}), 64'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // two-channel scan with fixed data
    ch_mask = 8'h05;
    sb.push_back(32'h0000_0ABC);
    sb.push_back(32'h2000_0123);
    repeat (REP) adc_q.push_back(16'h0ABC);
    repeat (REP) adc_q.push_back(16'h0123);
    v0 = n_valid;
    pulse_trigger();
    @(negedge clk);
    check("first_start", 64'({measure_start, measure_ch, busy}),
          64'({1'b1, 4'd0, 1'b1}));
    wait_idle(2000, cyc, pv);
    check("spec_words", 64'(n_valid - v0), 64'd2);
    check("busy_after_last_valid", 64'(pv), 64'd1);
    check("spec_sb_drained", 64'(sb.size()), 64'd0);
    exp_cnt++;

    enable  = 1'b0;
    ch_mask = 8'hFF;
    pulse_trigger();
    @(negedge clk);
    check("enable_low_ignored", 64'({busy, measure_start, overrun}), 64'd0);
    enable = 1'b1;

    foreach (tbl[i]) begin
      ch_mask = tbl[i].mask;
      v0 = n_valid;
      queue_scan(tbl[i].mask, tbl[i].base);
      pulse_trigger();
      @(negedge clk);
      ch_mask = ~tbl[i].mask;
      check("tbl_start", 64'(measure_start), 64'(tbl[i].words != 0));
      if (tbl[i].words != 0)
        check("tbl_first_ch", 64'(measure_ch), 64'(tbl[i].first_ch));
      wait_idle(4000, cyc, pv);
      check("tbl_words", 64'(n_valid - v0), 64'(tbl[i].words));
      check("tbl_flags", 64'({overrun, timeout}), 64'd0);
      if (tbl[i].words != 0) exp_cnt++;
    end

    // retrigger while scanning
    ch_mask = 8'hFF;
    v0 = n_valid;
    queue_scan(8'hFF, 16'h0A00);
    pulse_trigger();
    repeat (4) @(posedge clk);
    pulse_trigger();
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    wait_idle(4000, cyc, pv);
    check("overrun_words", 64'(n_valid - v0), 64'd8);
    repeat (3) @(negedge clk);
    check("overrun_no_rescan", 64'(busy), 64'd0);
    exp_cnt++;

    // enable dropped while channel 1 converts
    ch_mask = 8'h0F;
    v0 = n_valid;
    s0 = n_start;
    sb.push_back({4'd0, exp_cnt, 16'h0B00});
    sb.push_back({4'd1, exp_cnt, 16'h0B01});
    repeat (REP) adc_q.push_back(16'h0B00);
    repeat (REP) adc_q.push_back(16'h0B01);
    pulse_trigger();
    cyc = 0;
    while (!(measure_start && measure_ch == 4'd1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("en_drop_ch1_start", 64'({measure_start, measure_ch}),
          64'({1'b1, 4'd1}));
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_idle(2000, cyc, pv);
    check("en_drop_words", 64'(n_valid - v0), 64'd2);
    check("en_drop_starts", 64'(n_start - s0), 64'(2 * REP));
    enable = 1'b1;
    exp_cnt++;

    // conversion that never completes
    adc_en  = 1'b0;
    ch_mask = 8'h01;
    v0 = n_valid;
    pulse_trigger();
    @(negedge clk);
    check("to_start", 64'(measure_start), 64'd1);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("to_wait_cycles", 64'(cyc), 64'(TO + 1));
    check("to_flags", 64'({timeout, busy}), 64'({1'b1, 1'b0}));
    check("to_no_word", 64'(n_valid - v0), 64'd0);
    adc_en = 1'b1;

    // scan count must not advance on an aborted scan
    ch_mask = 8'h08;
    v0 = n_valid;
    queue_scan(8'h08, 16'h0D00);
    pulse_trigger();
    wait_idle(2000, cyc, pv);
    check("post_to_words", 64'(n_valid - v0), 64'd1);
    exp_cnt++;

    // reset in the middle of a conversion
    ch_mask = 8'h06;
    pulse_trigger();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    adc_cnt = 0;
    measure_done = 1'b0;
    sb.delete();
    adc_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_wait", 64'({busy, overrun, timeout, measure_start,
          data_out_valid, measure_ch, data_out}), 64'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_cnt = '0;

    v0 = n_valid;
    queue_scan(8'h06, 16'h0C00);
    pulse_trigger();
    @(negedge clk);
    check("restart_ch", 64'({measure_start, measure_ch}), 64'({1'b1, 4'd1}));
    wait_idle(2000, cyc, pv);
    check("restart_words", 64'(n_valid - v0), 64'd2);
    exp_cnt++;

`ifdef ADC_SCAN_AVG_EN
    ch_mask = 8'h01;
    v0 = n_valid;
    s0 = n_start;
    sb.push_back({4'd0, exp_cnt, 16'd11});
    adc_q.push_back(16'd10);
    adc_q.push_back(16'd11);
    adc_q.push_back(16'd12);
    adc_q.push_back(16'd14);
    pulse_trigger();
    wait_idle(2000, cyc, pv);
    check("avg_words", 64'(n_valid - v0), 64'd1);
    check("avg_starts", 64'(n_start - s0), 64'd4);
    exp_cnt++;
`endif

    check("final_sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
